// File: rtl/otdr_pkg.sv
// Shared definitions for the OTDR pulse burst generator: FSM encoding and default widths.
package otdr_pkg;
  localparam int CNT_W_DEF   = 16;
  localparam int BURST_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HIGH   = 2'd1,
    LOW    = 2'd2,
    FINISH = 2'd3
  } state_e;
endpackage

// File: rtl/otdr_down_counter.sv
// Loadable down counter; tc marks the last cycle of a loaded interval (count == 1).
module otdr_down_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_async,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);
  logic [CNT_W-1:0] cnt;

  // Stops at zero rather than wrapping to the maximum value.
  always_ff @(posedge clock or negedge reset_async) begin
    if (!reset_async)            cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (en && cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == CNT_W'(1));
endmodule

// File: rtl/otdr_pulse_burst_gen.sv
// Laser-drive pulse burst generator (finite or continuous) with acquisition trigger.
// Define PULSE_GEN_STATUS_EN to add the pulse_index status output.
module otdr_pulse_burst_gen
  import otdr_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clock,
  input  logic               reset_async,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   pulse_width,
  input  logic [CNT_W-1:0]   pulse_period,
  input  logic [BURST_W-1:0] pulse_count,
  output logic               pulse_out,
  output logic               acq_trig,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
`ifdef PULSE_GEN_STATUS_EN
  ,
  output logic [BURST_W-1:0] pulse_index
`endif
);
  state_e             state;
  logic [CNT_W-1:0]   w_sh, lo_sh;
  logic [BURST_W-1:0] n_sh, pulses;
  logic               abort_pend;
  logic               cfg_ok, accept, hi_tc, lo_tc, end_burst;
  logic               hi_load, lo_load;
  logic [CNT_W-1:0]   hi_val;

  assign cfg_ok    = (pulse_width != '0) && (pulse_period > pulse_width);
  assign accept    = (state == IDLE) && start && cfg_ok;
  // An abort arriving on the final LOW cycle still ends the burst there.
  assign end_burst = ((n_sh != '0) && (pulses == n_sh)) || abort_pend || abort;
  assign hi_load   = accept || ((state == LOW) && lo_tc && !end_burst);
  assign hi_val    = (state == IDLE) ? pulse_width : w_sh;
  assign lo_load   = (state == HIGH) && hi_tc;

  otdr_down_counter #(.CNT_W(CNT_W)) u_hi_cnt (
    .clock       (clock),
    .reset_async (reset_async),
    .load        (hi_load),
    .load_val    (hi_val),
    .en          (state == HIGH),
    .tc          (hi_tc)
  );

  otdr_down_counter #(.CNT_W(CNT_W)) u_lo_cnt (
    .clock       (clock),
    .reset_async (reset_async),
    .load        (lo_load),
    .load_val    (lo_sh),
    .en          (state == LOW),
    .tc          (lo_tc)
  );

  always_ff @(posedge clock or negedge reset_async) begin
    if (!reset_async) begin
      state      <= IDLE;
      pulse_out  <= 1'b0;
      acq_trig   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      w_sh       <= '0;
      lo_sh      <= '0;
      n_sh       <= '0;
      pulses     <= '0;
      abort_pend <= 1'b0;
    end else begin
      acq_trig <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      case (state)
        IDLE: begin
          abort_pend <= 1'b0;
          if (start && !cfg_ok) begin
            cfg_err <= 1'b1;
          end else if (accept) begin
            w_sh      <= pulse_width;
            lo_sh     <= pulse_period - pulse_width;
            n_sh      <= pulse_count;
            pulses    <= BURST_W'(1);
            state     <= HIGH;
            pulse_out <= 1'b1;
            acq_trig  <= 1'b1;
            busy      <= 1'b1;
          end
        end
        HIGH: begin
          if (abort) abort_pend <= 1'b1;
          if (hi_tc) begin
            state     <= LOW;
            pulse_out <= 1'b0;
          end
        end
        LOW: begin
          if (abort) abort_pend <= 1'b1;
          if (lo_tc) begin
            if (end_burst) begin
              state <= FINISH;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state     <= HIGH;
              pulse_out <= 1'b1;
              acq_trig  <= 1'b1;
              // Saturate so continuous mode never wraps back into a count match.
              if (pulses != {BURST_W{1'b1}}) pulses <= pulses + 1'b1;
            end
          end
        end
        FINISH: begin
          state      <= IDLE;
          abort_pend <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PULSE_GEN_STATUS_EN
  assign pulse_index = pulses;
`endif
endmodule
